// File: rtl/membrane_rmw_ctrl.sv
// membrane_rmw_ctrl: pipelined read-modify-write of packed saturating potentials in a dual-port BRAM, plus a full-memory zero sweep.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid/req_ready         update handshake; req_addr word address, req_delta LANES signed deltas
//   clear_start, busy           start a zero sweep of every address; busy while sweeping
//   done_valid, done_addr       one-cycle strobe per committed update write
//   bram_*_a                    read port (1-cycle registered read, read-first)
//   bram_*_b                    write port
module membrane_rmw_ctrl #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 11,
    parameter int POT_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_delta,
    input  logic                  clear_start,
    output logic                  busy,
    output logic                  done_valid,
    output logic [ADDR_WIDTH-1:0] done_addr,
    output logic                  bram_en_a,
    output logic                  bram_we_a,
    output logic [ADDR_WIDTH-1:0] bram_addr_a,
    input  logic [DATA_WIDTH-1:0] bram_dout_a,
    output logic                  bram_en_b,
    output logic                  bram_we_b,
    output logic [ADDR_WIDTH-1:0] bram_addr_b,
    output logic [DATA_WIDTH-1:0] bram_din_b
);
    localparam int LANES = DATA_WIDTH / POT_WIDTH;

    generate
        if (DATA_WIDTH % POT_WIDTH != 0) begin : g_bad_width
            $error("DATA_WIDTH must be a multiple of POT_WIDTH");
        end
    endgenerate

    typedef enum logic {ACTIVE, CLEAR} state_t;

    state_t                state, state_nxt;
    logic                  s1_valid, wb_valid, accept;
    logic [ADDR_WIDTH-1:0] s1_addr, wb_addr, cnt;
    logic [DATA_WIDTH-1:0] s1_delta, wb_data, old_word, new_word;
    logic [POT_WIDTH:0]    sum;

    // WB forwards the most recent write, covering the word whose read was
    // suppressed (same address as S1) or that was written after it was read.
    always_comb begin
        old_word = (wb_valid && wb_addr == s1_addr) ? wb_data : bram_dout_a;
        new_word = '0;
        sum      = '0;
        for (int i = 0; i < LANES; i++) begin
            sum = {old_word[i*POT_WIDTH+POT_WIDTH-1], old_word[i*POT_WIDTH +: POT_WIDTH]}
                + {s1_delta[i*POT_WIDTH+POT_WIDTH-1], s1_delta[i*POT_WIDTH +: POT_WIDTH]};
            // top two bits differing means overflow; the sign bit picks the rail
            new_word[i*POT_WIDTH +: POT_WIDTH] = (sum[POT_WIDTH] == sum[POT_WIDTH-1])
                ? sum[POT_WIDTH-1:0] : {sum[POT_WIDTH], {(POT_WIDTH-1){~sum[POT_WIDTH]}}};
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        busy        = 1'b0;
        done_valid  = 1'b0;
        done_addr   = '0;
        bram_we_b   = 1'b0;
        bram_addr_b = '0;
        bram_din_b  = '0;
        if (state == ACTIVE) begin
            req_ready   = !rst && !clear_start;
            bram_we_b   = s1_valid;
            bram_addr_b = s1_valid ? s1_addr : '0;
            bram_din_b  = s1_valid ? new_word : '0;
            done_valid  = s1_valid;
            done_addr   = s1_valid ? s1_addr : '0;
            state_nxt   = (clear_start && !rst) ? CLEAR : ACTIVE;
        end else begin
            busy        = 1'b1;
            bram_we_b   = 1'b1;
            bram_addr_b = cnt;
            state_nxt   = (&cnt) ? ACTIVE : CLEAR;
        end
        accept      = req_valid && req_ready;
        bram_en_a   = accept && !(s1_valid && req_addr == s1_addr);
        bram_we_a   = 1'b0;
        bram_addr_a = req_ready ? req_addr : '0;
        bram_en_b   = bram_we_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ACTIVE;
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_delta <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_nxt;
            s1_valid <= accept;
            if (accept) begin
                s1_addr  <= req_addr;
                s1_delta <= req_delta;
            end
            wb_valid <= (state == ACTIVE && state_nxt == CLEAR) ? 1'b0 : bram_we_b;
            if (bram_we_b) begin
                wb_addr <= bram_addr_b;
                wb_data <= bram_din_b;
            end
            cnt <= (state == CLEAR && state_nxt == CLEAR) ? cnt + 1'b1 : '0;
        end
    end
endmodule

// File: tb/tb_membrane_rmw_ctrl.sv
// tb_membrane_rmw_ctrl: table-driven and scoreboard checks of membrane_rmw_ctrl against a behavioural BRAM.
module tb_membrane_rmw_ctrl;
    typedef struct {logic [10:0] addr; logic [35:0] delta; logic [35:0] exp; logic en;} vec_t;
    typedef struct {logic [10:0] addr; logic [35:0] data;} sb_t;

    logic        clk, rst, req_valid, req_ready, clear_start, busy, done_valid;
    logic [10:0] req_addr, done_addr, bram_addr_a, bram_addr_b;
    logic [35:0] req_delta, bram_dout_a, bram_din_b;
    logic        bram_en_a, bram_we_a, bram_en_b, bram_we_b;
    logic [75:0] outs;
    logic [35:0] mem [2048];
    logic [35:0] ref_mem [2048];
    sb_t         q[$];
    sb_t         e;
    vec_t        tbl[14];
    int          tests = 0, fails = 0, sw_cnt = 0;

    membrane_rmw_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_delta(req_delta), .clear_start(clear_start),
        .busy(busy), .done_valid(done_valid), .done_addr(done_addr),
        .bram_en_a(bram_en_a), .bram_we_a(bram_we_a), .bram_addr_a(bram_addr_a),
        .bram_dout_a(bram_dout_a), .bram_en_b(bram_en_b), .bram_we_b(bram_we_b),
        .bram_addr_b(bram_addr_b), .bram_din_b(bram_din_b)
    );

    assign outs = {req_ready, busy, done_valid, done_addr, bram_en_a, bram_we_a, bram_addr_a,
                   bram_en_b, bram_we_b, bram_addr_b, bram_din_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_en_a) bram_dout_a <= mem[bram_addr_a];
        if (bram_en_b && bram_we_b) mem[bram_addr_b] <= bram_din_b;
    end

    task automatic check(input bit ok, input string nm, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [35:0] pk(int a, int b, int c, int d);
        logic [35:0] r;
        r[8:0] = a[8:0]; r[17:9] = b[8:0]; r[26:18] = c[8:0]; r[35:27] = d[8:0];
        return r;
    endfunction

    function automatic logic [35:0] rmw(logic [35:0] o, logic [35:0] d);
        logic [35:0] r;
        for (int i = 0; i < 4; i++) begin
            int s;
            s = int'(signed'(o[i*9 +: 9])) + int'(signed'(d[i*9 +: 9]));
            if (s > 255) s = 255;
            if (s < -256) s = -256;
            r[i*9 +: 9] = s[8:0];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            check(outs == 0, "rst_outs", outs, 0);
            sw_cnt = 0;
        end else begin
            check(bram_we_a == 0 && bram_en_b == bram_we_b, "port_roles",
                  {bram_we_a, bram_en_b, bram_we_b}, {1'b0, bram_we_b, bram_we_b});
            if (done_valid) begin
                if (q.size() == 0) check(0, "unexpected_done", done_addr, 0);
                else begin
                    e = q.pop_front();
                    check(bram_we_b == 1, "upd_we_b", bram_we_b, 1);
                    check(bram_addr_b == e.addr, "upd_addr_b", bram_addr_b, e.addr);
                    check(done_addr == e.addr, "done_addr", done_addr, e.addr);
                    check(bram_din_b == e.data, "upd_data", bram_din_b, e.data);
                end
            end else if (bram_we_b) begin
                check(bram_addr_b == sw_cnt[10:0], "sweep_addr", bram_addr_b, sw_cnt[10:0]);
                check(bram_din_b == 0, "sweep_data", bram_din_b, 0);
                check(busy && !req_ready, "sweep_flags", {busy, req_ready}, 2'b10);
                sw_cnt++;
            end
        end
    end

    task automatic send(input logic [10:0] a, input logic [35:0] d, input logic [35:0] x, input logic en);
        int w = 0;
        req_valid = 1'b1; req_addr = a; req_delta = d;
        #1;
        while (!req_ready && w < 10) begin @(posedge clk); #1; w++; end
        check(req_ready == 1, "req_ready", req_ready, 1);
        check(bram_en_a == en, "en_a", bram_en_a, en);
        check(bram_addr_a == a, "addr_a", bram_addr_a, a);
        q.push_back('{a, x});
        ref_mem[a] = x;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic sendm(input logic [10:0] a, input logic [35:0] d, input logic en);
        send(a, d, rmw(ref_mem[a], d), en);
    endtask

    task automatic start_clear();
        clear_start = 1'b1;
        #1;
        check(!req_ready, "ready_in_clear_cycle", req_ready, 0);
        @(posedge clk); #1;
        clear_start = 1'b0;
        check(busy == 1, "busy_after_start", busy, 1);
    endtask

    task automatic finish_clear(input bit poke, input int base);
        int k = 0;
        int nz = 0;
        while (busy && k < 2100) begin
            clear_start = poke && k == 50;
            @(posedge clk); #1;
            k++;
        end
        clear_start = 1'b0;
        check(k == 2048, "sweep_len", k, 2048);
        check(sw_cnt - base == 2048, "sweep_writes", sw_cnt - base, 2048);
        check(req_ready == 1, "ready_after_sweep", req_ready, 1);
        for (int i = 0; i < 2048; i++) begin
            if (mem[i] !== 36'd0) nz++;
            ref_mem[i] = '0;
        end
        check(nz == 0, "readback_nonzero", nz, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, w;
        tbl[0]  = '{11'd5,    pk(3, -2, 0, 100),       pk(3, -2, 0, 100),       1'b1};
        tbl[1]  = '{11'd9,    pk(250, -250, 0, 0),     pk(250, -250, 0, 0),     1'b1};
        tbl[2]  = '{11'd9,    pk(10, -10, -1, 1),      pk(255, -256, -1, 1),    1'b0};
        tbl[3]  = '{11'd7,    pk(1, 1, 1, 1),          pk(1, 1, 1, 1),          1'b1};
        tbl[4]  = '{11'd7,    pk(1, 1, 1, 1),          pk(2, 2, 2, 2),          1'b0};
        tbl[5]  = '{11'd7,    pk(1, 1, 1, 1),          pk(3, 3, 3, 3),          1'b0};
        tbl[6]  = '{11'd17,   pk(1, 1, 1, 1),          pk(1, 1, 1, 1),          1'b1};
        tbl[7]  = '{11'd18,   pk(1, 1, 1, 1),          pk(1, 1, 1, 1),          1'b1};
        tbl[8]  = '{11'd17,   pk(1, 1, 1, 1),          pk(2, 2, 2, 2),          1'b1};
        tbl[9]  = '{11'd5,    pk(-128, -128, -128, -128), pk(-125, -130, -128, -28), 1'b1};
        tbl[10] = '{11'd5,    pk(-255, -255, 255, 255), pk(-256, -256, 127, 227), 1'b0};
        tbl[11] = '{11'd2047, pk(255, -256, 1, -1),    pk(255, -256, 1, -1),    1'b1};
        tbl[12] = '{11'd0,    pk(-1, -1, -1, -1),      pk(-1, -1, -1, -1),      1'b1};
        tbl[13] = '{11'd2047, pk(255, 255, 0, 0),      pk(255, -1, 1, -1),      1'b1};
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_delta = '0; clear_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check(outs == 0, "reset_outs", outs, 0);
        rst = 1'b0;
        #1;
        check({busy, req_ready} == 2'b01, "idle_after_rst", {busy, req_ready}, 2'b01);
        base = sw_cnt;
        start_clear();
        finish_clear(1'b1, base);
        for (int i = 0; i < 14; i++) send(tbl[i].addr, tbl[i].delta, tbl[i].exp, tbl[i].en);
        @(posedge clk); #1;
        sendm(11'd3, pk(1, 1, 1, 1), 1'b1);
        base = sw_cnt;
        start_clear();
        finish_clear(1'b0, base);
        sendm(11'd9, pk(1, 1, 1, 1), 1'b1);
        sendm(11'd2047, pk(5, -5, 7, -7), 1'b1);
        @(posedge clk); #1;
        base = sw_cnt;
        start_clear();
        w = 0;
        while (sw_cnt - base < 100 && w < 300) begin @(posedge clk); #1; w++; end
        check(bram_we_b && bram_addr_b == 11'd100, "sweep_at_100", {bram_we_b, bram_addr_b}, {1'b1, 11'd100});
        rst = 1'b1;
        #1;
        check(outs == 0, "rst_mid_sweep", outs, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check({busy, req_ready} == 2'b01, "idle_after_abort", {busy, req_ready}, 2'b01);
        for (int i = 0; i < 100; i++) ref_mem[i] = '0;
        sendm(11'd9, pk(2, 2, 2, 2), 1'b1);
        sendm(11'd2047, pk(1, 1, 1, 1), 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check(q.size() == 0, "queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/membrane_rmw_ctrl.md
MEMBRANE_RMW_CTRL -- requirements
Module: membrane_rmw_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 36: BRAM word width, holding LANES packed potentials.
REQ-002 Parameter ADDR_WIDTH, default 11: BRAM address width; depth = 2**ADDR_WIDTH.
REQ-003 Parameter POT_WIDTH, default 9: signed two's-complement width of one potential; LANES = DATA_WIDTH/POT_WIDTH; DATA_WIDTH not divisible by POT_WIDTH shall be an elaboration error.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_valid  in  1  update request present.
REQ-007 req_ready  out  1  request accepted when req_valid and req_ready are both 1 at a rising edge.
REQ-008 req_addr  in  ADDR_WIDTH  word address to update.
REQ-009 req_delta  in  DATA_WIDTH  LANES signed deltas; lane i = bits [i*POT_WIDTH +: POT_WIDTH].
REQ-010 clear_start  in  1  request a zero sweep of the whole memory.
REQ-011 busy  out  1  high while the clear sweep runs.
REQ-012 done_valid  out  1  one-cycle strobe per committed request write; done_addr  out  ADDR_WIDTH  its address.
REQ-013 bram_en_a, bram_we_a  out  1 each; bram_addr_a  out  ADDR_WIDTH; bram_dout_a  in  DATA_WIDTH: read port, registered 1-cycle read latency, read-first on collision.
REQ-014 bram_en_b, bram_we_b  out  1 each; bram_addr_b  out  ADDR_WIDTH; bram_din_b  out  DATA_WIDTH: write port.

Function
REQ-015 States: ACTIVE, CLEAR; port A shall only read (bram_we_a = 0 always); port B shall only write (bram_en_b = bram_we_b).
REQ-016 req_ready = 1 iff state is ACTIVE, rst is 0 and clear_start is 0.
REQ-017 Acceptance cycle t: bram_addr_a = req_addr and bram_en_a = 1 (combinational); addr, delta and a valid bit captured into stage S1.
REQ-018 Cycle t+1 (S1 valid): per lane, new = sat(old + delta), written with bram_we_b = 1 and bram_addr_b = S1 addr; done_valid = 1 and done_addr = S1 addr in the same cycle; sustained throughput is one request per cycle.
REQ-019 sat(): compute sum at POT_WIDTH+1 bits; clamp to [-2**(POT_WIDTH-1), 2**(POT_WIDTH-1)-1]; lanes independent, no carry between lanes.
REQ-020 Write-back register WB (valid, addr, data) captures every port-B write at the edge it commits.
REQ-021 old = WB data when WB valid and WB addr == S1 addr; otherwise bram_dout_a.
REQ-022 An accepted request whose addr equals the S1 addr while S1 is valid shall drive bram_en_a = 0 (no same-address read/write collision); its old value comes from WB per REQ-021.
REQ-023 clear_start = 1 in ACTIVE at cycle c: no acceptance in c; any S1 write completes in c; at the end of c state becomes CLEAR, sweep counter = 0, WB valid = 0.
REQ-024 CLEAR: one write per cycle, bram_addr_b = counter, bram_din_b = 0, counter incremented; done_valid = 0; busy = 1; addresses 0 through 2**ADDR_WIDTH-1 each written exactly once, in order.
REQ-025 After the write of the last address, state returns to ACTIVE; busy = 0 and req_ready = 1 the next cycle, i.e. cycle c+2**ADDR_WIDTH+1.
REQ-026 clear_start during CLEAR shall be ignored; counter wrap never occurs.

Reset
REQ-027 While rst = 1: state ACTIVE, S1 and WB valid = 0, counter = 0, and all outputs 0 (req_ready, busy, done_valid, done_addr, all bram_* outputs).
REQ-028 Reset asserted mid-pipeline or mid-sweep shall abandon the operation; no write occurs after rst rises; first acceptance is possible in the first cycle with rst = 0.

Verification
REQ-029 Zeroed memory, accept addr 5, deltas {+3,-2,0,+100} -> next cycle bram_we_b = 1, addr 5, lanes {3,-2,0,100}, done_valid = 1, done_addr = 5.
REQ-030 Addr 9 preloaded with lanes {250,-250,0,0}, deltas {+10,-10,-1,+1} -> written lanes {255,-256,-1,1}.
REQ-031 Three back-to-back +1 requests to addr 7 from 0 -> successive writes 1, 2, 3; bram_en_a = 0 on the 2nd and 3rd acceptance.
REQ-032 Sequence addr 7, 8, 7, each delta +1, from 0 -> writes 7:1, 8:1, 7:2; no lost update.
REQ-033 clear_start while S1 holds a write to addr 3 -> addr-3 write completes, then 2048 zero writes to addresses 0..2047; busy = 1 and req_ready = 0 throughout; read-back of every address = 0.
REQ-034 rst pulsed at sweep address 100 -> all outputs 0 immediately, no further writes; after release busy = 0 and req_ready = 1.
